// File: rtl/game_match_scheduler.sv
// game_match_scheduler: runs a best-of-N match in front of full_game and time-slices its control input between two players.
// Ports: clk, rst_n (async active-low); start/seed begin a match; req/mode_a/mode_b are player mode requests;
//        gameover/who come from full_game; init/initial_val/control drive full_game; grant is the one-hot holder;
//        busy, score_a, score_b, match_done, match_winner report match progress.
// Define GAME_SCHED_FIXED_PRIO_EN to replace round-robin arbitration with fixed priority (A over B).
module game_match_scheduler #(
  parameter int MODE_SLOT       = 8,
  parameter int GAMES_PER_MATCH = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] seed,
  input  logic [1:0] req,
  input  logic [1:0] mode_a,
  input  logic [1:0] mode_b,
  input  logic       gameover,
  input  logic       who,
  output logic       init,
  output logic [3:0] initial_val,
  output logic [1:0] control,
  output logic [1:0] grant,
  output logic       busy,
  output logic [3:0] score_a,
  output logic [3:0] score_b,
  output logic       match_done,
  output logic       match_winner
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_RESULT = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam int SW = (MODE_SLOT > 1) ? $clog2(MODE_SLOT) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(MODE_SLOT - 1);
  localparam logic [3:0] WIN   = 4'(GAMES_PER_MATCH / 2 + 1);
  localparam logic [3:0] GAMES = 4'(GAMES_PER_MATCH);
  logic [2:0]    state_q, state_d;
  logic [3:0]    seed_q, seed_d;
  logic          init_q, init_d;
  logic [1:0]    control_q, control_d;
  logic [1:0]    grant_q, grant_d;
  logic          busy_q;
  logic [3:0]    sa_q, sa_d, sb_q, sb_d, games_q, games_d;
  logic [SW-1:0] slot_q, slot_d;
  logic          last_q, last_d;
  logic          first_q, first_d;
  logic          done_q, done_d;
  logic          winner_q, winner_d;
  logic          do_arb;
  logic [1:0]    pick, pick_mode;
  logic          rearb;
`ifdef GAME_SCHED_FIXED_PRIO_EN
  assign pick = req[0] ? 2'b01 : (req[1] ? 2'b10 : 2'b00);
`else
  // last_q: 0 = A served last, 1 = B served last; a lone requester is already one-hot
  assign pick = (req == 2'b11) ? (last_q ? 2'b01 : 2'b10) : req;
`endif
  assign pick_mode = pick[0] ? mode_a : (pick[1] ? mode_b : 2'b00);
  // an empty grant also counts as "holder not requesting", so idle slots re-arbitrate every cycle
  assign rearb = ((grant_q & req) == 2'b00) || (slot_q == SLOT_LAST);
  always_comb begin
    state_d   = state_q;
    seed_d    = seed_q;
    init_d    = 1'b0;
    control_d = control_q;
    grant_d   = grant_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    games_d   = games_q;
    slot_d    = slot_q;
    last_d    = last_q;
    first_d   = 1'b0;
    done_d    = 1'b0;
    winner_d  = winner_q;
    do_arb    = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_LOAD;
        seed_d  = seed;
        sa_d    = 4'd0;
        sb_d    = 4'd0;
        games_d = 4'd0;
        init_d  = 1'b1;
        slot_d  = '0;
      end
      S_LOAD: begin
        state_d = S_RUN;
        first_d = 1'b1;
        do_arb  = 1'b1;
      end
      S_RUN: if (gameover && !first_q) begin
        // score is taken on entry to RESULT so it is visible together with the cleared grant
        state_d   = S_RESULT;
        grant_d   = 2'b00;
        control_d = 2'b00;
        games_d   = games_q + 1'b1;
        sb_d      = (who && sb_q != 4'hf) ? sb_q + 1'b1 : sb_q;
        sa_d      = (!who && sa_q != 4'hf) ? sa_q + 1'b1 : sa_q;
      end else if (rearb) begin
        do_arb = 1'b1;
      end else begin
        slot_d = slot_q + 1'b1;
      end
      S_RESULT: if (sa_q >= WIN || sb_q >= WIN || games_q == GAMES) begin
        state_d  = S_DONE;
        done_d   = 1'b1;
        winner_d = sb_q > sa_q;
      end else begin
        state_d = S_LOAD;
        init_d  = 1'b1;
        slot_d  = '0;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (do_arb) begin
      grant_d   = pick;
      control_d = pick_mode;
      slot_d    = '0;
      last_d    = (|pick) ? pick[1] : last_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      seed_q    <= 4'd0;
      init_q    <= 1'b0;
      control_q <= 2'b00;
      grant_q   <= 2'b00;
      busy_q    <= 1'b0;
      sa_q      <= 4'd0;
      sb_q      <= 4'd0;
      games_q   <= 4'd0;
      slot_q    <= '0;
      last_q    <= 1'b1;
      first_q   <= 1'b0;
      done_q    <= 1'b0;
      winner_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      seed_q    <= seed_d;
      init_q    <= init_d;
      control_q <= control_d;
      grant_q   <= grant_d;
      busy_q    <= state_d != S_IDLE;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      games_q   <= games_d;
      slot_q    <= slot_d;
      last_q    <= last_d;
      first_q   <= first_d;
      done_q    <= done_d;
      winner_q  <= winner_d;
    end
  end
  assign init         = init_q;
  assign initial_val  = seed_q;
  assign control      = control_q;
  assign grant        = grant_q;
  assign busy         = busy_q;
  assign score_a      = sa_q;
  assign score_b      = sb_q;
  assign match_done   = done_q;
  assign match_winner = winner_q;
endmodule

// File: tb/tb_game_match_scheduler.sv
// tb_game_match_scheduler: self-checking bench for game_match_scheduler with scoreboard queues.
module tb_game_match_scheduler;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] seed = 4'd0;
  logic [1:0] req = 2'b00;
  logic [1:0] mode_a = 2'b00;
  logic [1:0] mode_b = 2'b00;
  logic       gameover = 1'b0;
  logic       who = 1'b0;
  logic       init;
  logic [3:0] initial_val;
  logic [1:0] control;
  logic [1:0] grant;
  logic       busy;
  logic [3:0] score_a;
  logic [3:0] score_b;
  logic       match_done;
  logic       match_winner;
  int n_checks = 0;
  int n_fail = 0;
  game_match_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .req(req),
    .mode_a(mode_a), .mode_b(mode_b), .gameover(gameover), .who(who),
    .init(init), .initial_val(initial_val), .control(control), .grant(grant),
    .busy(busy), .score_a(score_a), .score_b(score_b),
    .match_done(match_done), .match_winner(match_winner)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic apply_reset();
    rst_n = 1'b0;
    start = 1'b0;
    gameover = 1'b0;
    who = 1'b0;
    req = 2'b00;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask
  task automatic test_reset();
    logic [21:0] outs;
    rst_n = 1'b0;
    start = 1'b1;
    seed = 4'h5;
    req = 2'b11;
    mode_a = 2'b01;
    mode_b = 2'b10;
    repeat (3) @(posedge clk);
    #1;
    outs = {init, initial_val, control, grant, busy, score_a, score_b, match_done, match_winner};
    n_checks++;
    if (outs !== 22'd0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", outs); end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (init !== 1'b1) begin n_fail++; $display("FAIL reset_init_pulse: got %b expected 1", init); end
    n_checks++;
    if (initial_val !== 4'h5) begin n_fail++; $display("FAIL reset_initial_val: got %h expected 5", initial_val); end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b expected 1", busy); end
    n_checks++;
    if ({grant, control} !== 4'b0000) begin n_fail++; $display("FAIL load_grant: got %b expected 0000", {grant, control}); end
    start = 1'b0;
    tick();
    n_checks++;
    if (init !== 1'b0) begin n_fail++; $display("FAIL init_one_cycle: got %b expected 0", init); end
    n_checks++;
    if ({grant, control} !== 4'b0101) begin n_fail++; $display("FAIL first_grant: got %b expected 0101", {grant, control}); end
  endtask
  task automatic test_round_robin();
    logic [3:0] exp_q[$];
    logic [3:0] e;
    apply_reset();
    req = 2'b11;
    mode_a = 2'b01;
    mode_b = 2'b10;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 24; k++)
      exp_q.push_back(k < 8 ? 4'b0101 : (k < 16 ? 4'b1010 : 4'b0111));
    for (int k = 0; k < 24; k++) begin
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if ({grant, control} !== e) begin n_fail++; $display("FAIL rr_cycle%0d: got %b expected %b", k, {grant, control}, e); end
      if (k == 3) mode_a = 2'b11;
    end
    gameover = 1'b1;
    who = 1'b0;
    tick();
    gameover = 1'b0;
    n_checks++;
    if ({grant, control} !== 4'b0000) begin n_fail++; $display("FAIL slot_boundary_gameover: got %b expected 0000", {grant, control}); end
    n_checks++;
    if (score_a !== 4'd1) begin n_fail++; $display("FAIL rr_score_a: got %0d expected 1", score_a); end
    tick();
    n_checks++;
    if (init !== 1'b1) begin n_fail++; $display("FAIL rr_next_init: got %b expected 1", init); end
  endtask
  task automatic test_drop_req();
    apply_reset();
    req = 2'b11;
    mode_a = 2'b01;
    mode_b = 2'b10;
    start = 1'b1;
    tick();
    repeat (3) tick();
    req = 2'b10;
    tick();
    n_checks++;
    if ({grant, control} !== 4'b1010) begin n_fail++; $display("FAIL drop_req_handover: got %b expected 1010", {grant, control}); end
    n_checks++;
    if (init !== 1'b0) begin n_fail++; $display("FAIL start_while_busy: got %b expected 0", init); end
    req = 2'b11;
    mode_b = 2'b11;
    tick();
    n_checks++;
    if ({grant, control} !== 4'b1010) begin n_fail++; $display("FAIL no_preempt_hold_mode: got %b expected 1010", {grant, control}); end
    start = 1'b0;
  endtask
  task automatic test_match(input logic [2:0] whos, input int n_exp);
    logic [7:0] sc_q[$];
    logic       win_q[$];
    logic [7:0] e;
    logic [1:0] eg;
    logic       w;
    int sa, sb, g, inits;
    bit done;
    sa = 0; sb = 0; g = 0; inits = 0; done = 0;
    apply_reset();
    req = 2'b11;
    mode_a = 2'b01;
    mode_b = 2'b10;
    seed = 4'h9;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (!done && g < 4) begin
      n_checks++;
      if (init !== 1'b1) begin n_fail++; $display("FAIL match_init_g%0d: got %b expected 1", g, init); end
      inits++;
      tick();
      gameover = 1'b1;
      who = whos[g];
      tick();
      eg = (g % 2 == 0) ? 2'b01 : 2'b10;
      n_checks++;
      if (grant !== eg) begin n_fail++; $display("FAIL match_first_cycle_ignore_g%0d: got %b expected %b", g, grant, eg); end
      if (whos[g]) sb++; else sa++;
      g++;
      sc_q.push_back({4'(sa), 4'(sb)});
      done = (sa >= 2) || (sb >= 2) || (g == 3);
      if (done) win_q.push_back(sb > sa);
      tick();
      gameover = 1'b0;
      e = sc_q.pop_front();
      n_checks++;
      if ({score_a, score_b} !== e || grant !== 2'b00) begin
        n_fail++;
        $display("FAIL match_score_g%0d: got a=%0d b=%0d grant=%b expected a=%0d b=%0d grant=00", g, score_a, score_b, grant, e[7:4], e[3:0]);
      end
      tick();
      if (done) begin
        w = win_q.pop_front();
        n_checks++;
        if (match_done !== 1'b1 || init !== 1'b0) begin n_fail++; $display("FAIL match_done_pulse: got done=%b init=%b expected done=1 init=0", match_done, init); end
        n_checks++;
        if (match_winner !== w) begin n_fail++; $display("FAIL match_winner: got %b expected %b", match_winner, w); end
      end
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || match_done !== 1'b0) begin n_fail++; $display("FAIL match_idle: got busy=%b done=%b expected 0 0", busy, match_done); end
    n_checks++;
    if ({score_a, score_b} !== {4'(sa), 4'(sb)}) begin n_fail++; $display("FAIL match_score_held: got %h expected %h", {score_a, score_b}, {4'(sa), 4'(sb)}); end
    repeat (4) begin
      if (init === 1'b1) inits++;
      tick();
    end
    n_checks++;
    if (inits != n_exp) begin n_fail++; $display("FAIL match_init_count: got %0d expected %0d", inits, n_exp); end
  endtask
  task automatic test_async_reset();
    apply_reset();
    req = 2'b01;
    mode_a = 2'b01;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    gameover = 1'b1;
    who = 1'b1;
    tick();
    tick();
    gameover = 1'b0;
    tick();
    tick();
    n_checks++;
    if (grant !== 2'b01 || score_b !== 4'd1) begin n_fail++; $display("FAIL areset_setup: got grant=%b b=%0d expected grant=01 b=1", grant, score_b); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (grant !== 2'b00 || busy !== 1'b0) begin n_fail++; $display("FAIL areset_immediate: got grant=%b busy=%b expected 00 0", grant, busy); end
    n_checks++;
    if (score_b !== 4'd0 || control !== 2'b00) begin n_fail++; $display("FAIL areset_scores: got b=%0d control=%b expected 0 00", score_b, control); end
    tick();
    rst_n = 1'b1;
  endtask
  initial begin
    test_reset();
    test_round_robin();
    test_drop_req();
    test_match(3'b000, 2);
    test_match(3'b101, 3);
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/game_match_scheduler.md
# game_match_scheduler

Sequencer and arbiter that sits in front of `full_game` and drives its `init`, `initial_val` and `control` inputs. It runs a best-of-N match as a series of games and shares the counter's mode input between two players using time slots. It watches `gameover`/`who` to score each game and reports the match winner.

## Interface
- `MODE_SLOT`, 8, cycles a granted player keeps the control input (min 1)
- `GAMES_PER_MATCH`, 3, maximum games per match, odd, 1..15
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  match start request, sampled in IDLE only
- `seed`  in  4  initial counter value, captured when `start` is accepted
- `req`  in  2  mode requests: bit0 = player A, bit1 = player B
- `mode_a`  in  2  control mode requested by player A
- `mode_b`  in  2  control mode requested by player B
- `gameover`  in  1  level from `full_game`
- `who`  in  1  from `full_game`: 0 credits player A, 1 credits player B
- `init`  out  1  one-cycle load pulse to `full_game`
- `initial_val`  out  4  captured seed
- `control`  out  2  registered mode of the current grant holder
- `grant`  out  2  one-hot grant, 00 = none
- `busy`  out  1  high in every state except IDLE
- `score_a`, `score_b`  out  4  games won in the current match
- `match_done`  out  1  one-cycle pulse at match end
- `match_winner`  out  1  0 = A, 1 = B, valid from `match_done` until the next accepted `start`

## Operation
- FSM states: IDLE, LOAD, RUN, RESULT, DONE.
- IDLE:
  - when `start`=1: capture `seed`, clear scores and games counter, go to LOAD.
- LOAD:
  - `init`=1, `control`=00, `grant`=00 for exactly one cycle, then go to RUN.
  - Slot counter cleared; last-served pointer is not changed.
- RUN, arbitration:
  - Arbitrate in the first RUN cycle.
  - Re-arbitrate when the slot counter reaches `MODE_SLOT`-1, or when the holder's `req` bit is 0.
  - Round-robin: the player not served last wins if it requests; otherwise the requester is granted.
  - On grant, load the holder's mode into `control`. It stays held for the whole slot, even if `mode_x` changes mid-slot.
  - No requester: `grant`=00, `control`=00.
- RUN, gameover:
  - `gameover` is ignored in the first RUN cycle, because the counter is still settling after `init`.
  - After that, `gameover`=1 goes to RESULT. `grant` and `control` clear on entry to RESULT.
- RESULT:
  - Increment the score selected by `who` and increment the games counter.
  - If that score ≥ `GAMES_PER_MATCH`/2+1, or games played = `GAMES_PER_MATCH`, go to DONE; otherwise go to LOAD.
- DONE:
  - `match_done`=1 for one cycle.
  - `match_winner` = 1 if `score_b` > `score_a`, else 0.
  - Return to IDLE.
- Scores saturate at 15. They are held in IDLE until the next accepted `start`.

## Timing
- Reset values: `init`=0, `initial_val`=0, `control`=00, `grant`=00, `busy`=0, `score_a`=`score_b`=0, `match_done`=0, `match_winner`=0, FSM=IDLE, last-served = B (so A wins the first tie).
- Reset mid-operation: all outputs go to their reset values immediately (asynchronous); the match is abandoned.
- All outputs are registered.
- Latencies:
  - `start` sampled at edge n: `init`=1 during cycle n+1, first grant visible at n+2.
  - `gameover` sampled at edge m: `grant`=00 and scores updated at m+1, next `init` (or `match_done`) at m+2.
- Simultaneous events:
  - `gameover` on a slot-boundary cycle: the game ends and no new grant is issued.
  - `start` while `busy`: ignored.
  - Holder drops `req` and the other player requests in the same cycle: the other player is granted on the next edge.
- `MODE_SLOT`=1: re-arbitrate every cycle, so grants alternate when both players request.

## Configuration
- `GAME_SCHED_FIXED_PRIO_EN`:
  - Defined: round-robin is replaced by fixed priority, player A over player B. B is granted only when `req[0]`=0. Slot expiry still re-arbitrates.
  - Undefined: round-robin as above.

## Test plan
- Reset with `start` high → all outputs at reset values; after release with `start`=1, `seed`=4'h5 → `init` pulse one cycle, `initial_val`=5, `busy`=1.
- `req`=11, `mode_a`=01, `mode_b`=10, `MODE_SLOT`=8 → `grant` 01 for 8 cycles (`control`=01), then 10 for 8 cycles (`control`=10), then repeats.
- Player A drops `req` at cycle 3 of its slot while B requests → `grant`=10 on the next edge, `control`=`mode_b`.
- Game results `who` = 0, 0 with `GAMES_PER_MATCH`=3 → match ends after 2 games, `score_a`=2, `match_done` pulse, `match_winner`=0, no third `init`.
- Game results `who` = 1, 0, 1 → three `init` pulses, `score_b`=2, `score_a`=1, `match_winner`=1.
- Assert `rst_n`=0 during RUN with `grant`=01 → `grant`=00 and `busy`=0 immediately, without waiting for a clock edge; scores cleared.
